// File: rtl/case_conv_pkg.sv
// ---------------------------------------------------------------------------
// case_conv_pkg
//   Constants and helpers shared by the ASCII case converters (this lowercase
//   folder and the existing uppercase converter).
//
//   Contents:
//     UPPER_A / UPPER_Z  : bounds of the uppercase letter range (0x41..0x5A)
//     LOWER_A / LOWER_Z  : bounds of the lowercase letter range (0x61..0x7A)
//     CASE_OFFSET        : distance between the two letter ranges (0x20)
//     BUF_DEPTH          : entries in the streaming output buffer
//     occ_e              : buffer occupancy encoding
//     is_upper_byte()    : byte lies in UPPER_A..UPPER_Z
//     is_lower_byte()    : byte lies in LOWER_A..LOWER_Z
// ---------------------------------------------------------------------------
package case_conv_pkg;

  localparam logic [7:0] UPPER_A     = 8'h41;
  localparam logic [7:0] UPPER_Z     = 8'h5A;
  localparam logic [7:0] LOWER_A     = 8'h61;
  localparam logic [7:0] LOWER_Z     = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;
  localparam int         BUF_DEPTH   = 2;

  // Occupancy of the output buffer; the value equals the number of entries.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Bytes 0x80..0xFF fall outside both ranges and are never letters.
  function automatic logic is_upper_byte(input logic [7:0] b);
    return (b >= UPPER_A) && (b <= UPPER_Z);
  endfunction

  function automatic logic is_lower_byte(input logic [7:0] b);
    return (b >= LOWER_A) && (b <= LOWER_Z);
  endfunction

endpackage

// File: rtl/case_fold_byte.sv
// ---------------------------------------------------------------------------
// case_fold_byte
//   Purely combinational lowercase fold of one byte. Uppercase ASCII letters
//   are shifted down into the lowercase range; every other byte, including
//   the neighbours '@' (0x40) and '[' (0x5B) and all of 0x80..0xFF, passes
//   through unchanged.
//
//   Ports:
//     in_byte  [7:0] in  : byte to fold
//     out_byte [7:0] out : folded byte
//     is_upper       out : in_byte was an uppercase letter (was converted)
// ---------------------------------------------------------------------------
module case_fold_byte
  import case_conv_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte,
  output logic       is_upper
);

  always_comb begin
    is_upper = is_upper_byte(in_byte);
    out_byte = in_byte;
    if (is_upper) begin
      out_byte = in_byte + CASE_OFFSET;
    end
  end

endmodule

// File: rtl/to_lower_stream.sv
// ---------------------------------------------------------------------------
// to_lower_stream
//   Streaming ASCII lowercase folder with a valid/ready handshake on both
//   sides. Bytes are folded as they are accepted and held in a 2-entry FIFO
//   that absorbs sink backpressure while still sustaining one byte per cycle
//   when the sink is always ready.
//
//   Build option: define TO_LOWER_STATS_EN to build the saturating
//   byte_count / conv_count statistics. Without it the counter outputs are
//   tied to zero and stats_clr is ignored; the data path is identical.
//
//   Ports:
//     clk               in  : clock, all state on its rising edge
//     rst               in  : synchronous active-high reset
//     in_valid          in  : in_data holds a byte
//     in_ready          out : a byte can be accepted this cycle
//     in_data   [7:0]   in  : input byte
//     out_valid         out : out_data holds a folded byte
//     out_ready         in  : sink takes out_data this cycle
//     out_data  [7:0]   out : head of the buffer (holds last value when idle)
//     stats_clr         in  : synchronous clear of both counters
//     byte_count[CNT_W] out : bytes accepted (saturating)
//     conv_count[CNT_W] out : accepted bytes that were uppercase (saturating)
// ---------------------------------------------------------------------------
module to_lower_stream
  import case_conv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] byte_count,
  output logic [CNT_W-1:0] conv_count
);

  localparam int IDX_W = $clog2(BUF_DEPTH);

  occ_e             occ_q, occ_d;
  logic [7:0]       buf_q [BUF_DEPTH];
  logic [7:0]       buf_d [BUF_DEPTH];
  logic             push;
  logic             pop;
  logic             shift;
  logic [IDX_W-1:0] wr_idx;
  logic [7:0]       fold_byte;
  logic             fold_is_upper;

  case_fold_byte u_fold (
    .in_byte  (in_data),
    .out_byte (fold_byte),
    .is_upper (fold_is_upper)
  );

  // in_ready looks only at registered occupancy (and rst), never at
  // out_ready, so no combinational path runs from sink to source.
  assign in_ready  = (occ_q != OCC_FULL) && !rst;
  assign out_valid = (occ_q != OCC_EMPTY);
  assign out_data  = buf_q[0];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Occupancy FSM.
  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (push) occ_d = OCC_ONE;
      end
      OCC_ONE: begin
        if (push && !pop)      occ_d = OCC_FULL;
        else if (!push && pop) occ_d = OCC_EMPTY;
      end
      OCC_FULL: begin
        if (pop) occ_d = OCC_ONE;
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  // Slot 0 is always the head. Entries move toward the head only when a
  // second entry exists behind it; popping the last entry leaves slot 0
  // untouched so out_data keeps its last value while idle.
  always_comb begin
    shift  = pop && (occ_q == OCC_FULL);
    wr_idx = '0;
    // With one entry and no pop the new byte goes behind the head; with a
    // simultaneous pop it replaces the head directly.
    if ((occ_q == OCC_ONE) && !pop) begin
      wr_idx = IDX_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_slot
      logic [7:0] next_up;
      if (gi < BUF_DEPTH - 1) begin : g_link
        assign next_up = buf_q[gi+1];
      end else begin : g_last
        assign next_up = buf_q[gi];
      end
      assign buf_d[gi] = (push && (wr_idx == IDX_W'(gi))) ? fold_byte :
                         shift                            ? next_up   :
                                                            buf_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= OCC_EMPTY;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      occ_q <= occ_d;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

`ifdef TO_LOWER_STATS_EN
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] conv_cnt_q, conv_cnt_d;

  // Clear has priority over a coincident push; both counters stop at
  // all-ones instead of wrapping.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    conv_cnt_d = conv_cnt_q;
    if (stats_clr) begin
      byte_cnt_d = '0;
      conv_cnt_d = '0;
    end else if (push) begin
      if (byte_cnt_q != '1) begin
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
      end
      if (fold_is_upper && (conv_cnt_q != '1)) begin
        conv_cnt_d = conv_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      conv_cnt_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      conv_cnt_q <= conv_cnt_d;
    end
  end

  assign byte_count = byte_cnt_q;
  assign conv_count = conv_cnt_q;
`else
  // Statistics not built: outputs constant, clear and flag have no sink.
  logic unused_stats;
  assign unused_stats = stats_clr | fold_is_upper;
  assign byte_count   = '0;
  assign conv_count   = '0;
`endif

endmodule

// File: doc/to_lower_stream.md
# to_lower_stream

Streaming ASCII case folder: accepts one byte per cycle over a valid/ready handshake, maps uppercase letters `A`–`Z` (0x41–0x5A) to lowercase (+0x20), and passes every other byte unchanged, including 0x80–0xFF. It is the inverse of the existing uppercase converter. It sits between a byte source (UART receive, text buffer) and a byte sink, with a 2-entry output buffer that absorbs sink backpressure.

## Interface

Parameters:
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: `in_data` holds a byte.
- `in_ready` output 1: block can accept a byte this cycle.
- `in_data` input 8: input byte.
- `out_valid` output 1: `out_data` holds a converted byte.
- `out_ready` input 1: sink takes the byte this cycle.
- `out_data` output 8: converted byte.
- `stats_clr` input 1: synchronous clear of both counters.
- `byte_count` output `CNT_W`: number of bytes accepted.
- `conv_count` output `CNT_W`: number of accepted bytes that were converted.

## Operation

- Push: `in_valid && in_ready`. Pop: `out_valid && out_ready`.
- Conversion is applied at push time. A byte b in [0x41, 0x5A] is stored as b + 0x20. Every other byte is stored unchanged. Boundary bytes 0x40 (`@`) and 0x5B (`[`) are not converted.
- The buffer is a 2-entry FIFO. Occupancy states: EMPTY (0), ONE (1), FULL (2).
  - EMPTY: push → ONE.
  - ONE: push without pop → FULL; pop without push → EMPTY; push and pop together → stays ONE.
  - FULL: pop → ONE. No push is possible in FULL.
- Output signals:
  - `in_ready` = occupancy != FULL, and 0 while `rst` is high.
  - `out_valid` = occupancy != EMPTY.
  - `out_data` = head entry, held stable while `out_valid && !out_ready`.
- Ordering is strict FIFO. No byte is dropped or duplicated.
- Behaviour of `out_data` when `out_valid` is 0: it holds its last value. After reset it is 0x00.
- Counters (with the macro defined):
  - `byte_count` increments on each push.
  - `conv_count` increments on each push of a byte in [0x41, 0x5A].
  - Both saturate at all-ones.
  - `stats_clr` zeroes both counters. When a push coincides with `stats_clr`, the clear wins and the counter is 0 next cycle.

## Timing

- Reset values: occupancy EMPTY, `out_valid`=0, `out_data`=0x00, `byte_count`=0, `conv_count`=0. `in_ready`=1 in the first cycle after `rst` falls.
- Reset mid-operation flushes all buffered bytes. Nothing is emitted afterwards, and counters are zeroed.
- Latency: a byte pushed at edge N is presented with `out_valid`=1 from edge N onward, so it can be popped at edge N+1.
- Throughput: with `out_ready` held at 1, one byte per cycle is sustained indefinitely.
- `in_ready` has no combinational path from `out_ready`. It depends only on registered occupancy.
- Counter outputs are registered and reflect a push one cycle after the accepting edge.

## Configuration

- Macro: `TO_LOWER_STATS_EN`.
- Defined: `byte_count` and `conv_count` are implemented as described in Operation.
- Undefined:
  - Counter registers are not built, and both outputs are tied to 0.
  - `stats_clr` is ignored.
  - Ports remain present so benches and instantiations are unchanged.
  - Data path and timing are identical in both builds.

## Structure

- Shared package `case_conv_pkg` holds:
  - `UPPER_A`=8'h41, `UPPER_Z`=8'h5A, `LOWER_A`=8'h61, `LOWER_Z`=8'h7A.
  - `CASE_OFFSET`=8'h20.
  - `BUF_DEPTH`=2.
  - These constants are shared with the uppercase converter.
- One sub-module, `case_fold_byte`: purely combinational. Takes the 8-bit input and returns the folded byte plus an `is_upper` flag. The FIFO and counters stay in `to_lower_stream`.

## Test plan

- Conversion with `out_ready`=1: push `H` 0x48, `A` 0x41, `Z` 0x5A, `@` 0x40, `[` 0x5B, `|` 0x7C, 0xEB, 0xCF, DEL 0x7F → outputs 0x68, 0x61, 0x7A, 0x40, 0x5B, 0x7C, 0xEB, 0xCF, 0x7F in order. Each appears one edge after its push. Expect `byte_count`=9, `conv_count`=3.
- Backpressure: hold `out_ready`=0 and push 0x47, 0x4D, 0x30.
  - First two are accepted; `in_ready`=0 after the second; 0x30 is held at the input.
  - `out_data`=0x67 stays stable.
  - Release `out_ready` → 0x67, 0x6D, 0x30 are output.
- Simultaneous push and pop at ONE, sustained for 20 cycles with random bytes → occupancy stays ONE, no gaps, output matches the reference fold function.
- Reset mid-stream: FULL with 0x61 and 0x62, assert `rst` for 1 cycle → `out_valid`=0, `out_data`=0x00, counters 0, and neither buffered byte is ever emitted.
- Stats (macro defined):
  - Push 0x41 65535 times plus 2 more → both counters = 0xFFFF.
  - `stats_clr` together with a push → both counters 0.
  - Macro undefined → both counters always 0.
